// File: rtl/mem_writer_if.sv
// Producer/SRAM-write bus for mem_writer: frame control, word handshake,
// SRAM write port and frame status.
interface mem_writer_if #(
    parameter int unsigned MAX_ADDR  = 10,
    parameter int unsigned DATA_SIZE = 32
);
    logic                 start;
    logic                 valid_in;
    logic [DATA_SIZE-1:0] data_in;
    logic                 ready;
    logic                 sram_we;
    logic [MAX_ADDR-1:0]  sram_addr;
    logic [DATA_SIZE-1:0] sram_data;
    logic [MAX_ADDR:0]    word_count;
    logic                 busy;
    logic                 done;

    modport master (
        output start, valid_in, data_in,
        input  ready, sram_we, sram_addr, sram_data, word_count, busy, done
    );

    modport slave (
        input  start, valid_in, data_in,
        output ready, sram_we, sram_addr, sram_data, word_count, busy, done
    );
endinterface

// File: rtl/mem_writer.sv
// Frame writer: accepts MAX_INPUT words per frame from a valid/ready producer
// and writes them to consecutive SRAM addresses with a registered write port.
module mem_writer #(
    parameter int unsigned MAX_ADDR      = 10,
    parameter int unsigned DATA_SIZE     = 32,
    parameter int unsigned MAX_LOCATIONS = 1024,
    parameter int unsigned MAX_INPUT     = 90
) (
    input logic         pulse,
    input logic         rst,
    mem_writer_if.slave bus
);
    localparam int unsigned CNT_W = MAX_ADDR + 1;
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(MAX_INPUT);
    localparam logic [MAX_ADDR-1:0] PTR_MAX  = MAX_ADDR'(MAX_LOCATIONS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [MAX_ADDR-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [MAX_ADDR-1:0]  addr_q, addr_d;
    logic [DATA_SIZE-1:0] data_q, data_d;
    logic                 busy_q, done_q;
    logic                 ready_c;
    logic                 hs_c;

    assign ready_c = (state_q == WRITE) && (cnt_q < LAST_CNT);
    assign hs_c    = bus.valid_in && ready_c;

    // Next-state, pointer/count and write-port staging
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = WRITE;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                if (hs_c) begin
                    we_d   = 1'b1;
                    addr_d = ptr_q;
                    data_d = bus.data_in;
                    // Pointer saturates so a full-depth frame never wraps
                    ptr_d  = (ptr_q == PTR_MAX) ? ptr_q : ptr_q + MAX_ADDR'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == LAST_CNT) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge pulse) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= (state_d == WRITE) || (state_d == FLUSH);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.ready      = ready_c;
    assign bus.sram_we    = we_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_data  = data_q;
    assign bus.word_count = cnt_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_mem_writer.sv
// Scoreboard bench for mem_writer: a 90-word instance and a 1-word instance,
// with expected SRAM writes queued by stimulus and checked by monitors.
module tb_mem_writer;
    typedef struct {
        int          addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic pulse = 1'b0;
    logic rst   = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    mem_writer_if #(.MAX_ADDR(10), .DATA_SIZE(32)) m ();
    mem_writer_if #(.MAX_ADDR(10), .DATA_SIZE(32)) s ();

    mem_writer #(.MAX_ADDR(10), .DATA_SIZE(32), .MAX_LOCATIONS(1024), .MAX_INPUT(90))
        u0 (.pulse(pulse), .rst(rst), .bus(m.slave));
    mem_writer #(.MAX_ADDR(10), .DATA_SIZE(32), .MAX_LOCATIONS(1024), .MAX_INPUT(1))
        u1 (.pulse(pulse), .rst(rst), .bus(s.slave));

    always #5 pulse = ~pulse;
    always @(posedge pulse) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge pulse);
        #1;
    endtask

    task automatic send0(input logic [31:0] d, input int addr);
        m.valid_in = 1'b1;
        m.data_in  = d;
        chk("u0_ready_hs", 64'(m.ready), 64'd1);
        q0.push_back('{addr, d, cyc + 1});
        step();
        m.valid_in = 1'b0;
    endtask

    // Monitors: a due entry must appear as a write exactly one cycle after its handshake
    always @(negedge pulse) begin
        if (q0.size() != 0 && q0[0].due <= cyc) begin
            e0 = q0.pop_front();
            chk("u0_we", 64'(m.sram_we), 64'd1);
            if (m.sram_we === 1'b1) begin
                chk("u0_addr", 64'(m.sram_addr), 64'(e0.addr));
                chk("u0_data", 64'(m.sram_data), 64'(e0.data));
                chk("u0_latency", 64'(cyc), 64'(e0.due));
            end
        end else if (m.sram_we === 1'b1) begin
            chk("u0_we_unexpected", 64'(m.sram_we), 64'd0);
        end
    end

    always @(negedge pulse) begin
        if (q1.size() != 0 && q1[0].due <= cyc) begin
            e1 = q1.pop_front();
            chk("u1_we", 64'(s.sram_we), 64'd1);
            if (s.sram_we === 1'b1) begin
                chk("u1_addr", 64'(s.sram_addr), 64'(e1.addr));
                chk("u1_data", 64'(s.sram_data), 64'(e1.data));
            end
        end else if (s.sram_we === 1'b1) begin
            chk("u1_we_unexpected", 64'(s.sram_we), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        m.start = 1'b0; m.valid_in = 1'b0; m.data_in = '0;
        s.start = 1'b0; s.valid_in = 1'b0; s.data_in = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 64'(m.ready), 64'd0);
        chk("rst_busy", 64'(m.busy), 64'd0);
        chk("rst_done", 64'(m.done), 64'd0);
        chk("rst_count", 64'(m.word_count), 64'd0);
        chk("rst_we", 64'(m.sram_we), 64'd0);
        chk("rst_addr", 64'(m.sram_addr), 64'd0);
        chk("rst_data", 64'(m.sram_data), 64'd0);

        // valid_in while IDLE is refused
        m.valid_in = 1'b1; m.data_in = 32'hBAD0_0001;
        chk("idle_ready", 64'(m.ready), 64'd0);
        step(); step();
        chk("idle_count", 64'(m.word_count), 64'd0);
        chk("idle_busy", 64'(m.busy), 64'd0);

        // start together with valid_in: the word is not taken
        m.start = 1'b1; m.data_in = 32'hBAD0_0002;
        chk("start_ready", 64'(m.ready), 64'd0);
        step();
        m.start = 1'b0; m.valid_in = 1'b0;
        chk("write_busy", 64'(m.busy), 64'd1);
        chk("write_count0", 64'(m.word_count), 64'd0);
        chk("write_ready", 64'(m.ready), 64'd1);

        // 90 back-to-back words; a start at word 10 must be ignored
        for (int i = 0; i < 90; i++) begin
            m.start = (i == 10);
            send0(32'hD000_0000 | 32'(i), i);
            m.start = 1'b0;
            if (i == 10) chk("start_ignored_count", 64'(m.word_count), 64'd11);
        end
        chk("flush_busy", 64'(m.busy), 64'd1);
        chk("flush_done", 64'(m.done), 64'd0);
        chk("flush_count", 64'(m.word_count), 64'd90);
        chk("flush_ready", 64'(m.ready), 64'd0);
        step();
        chk("done_done", 64'(m.done), 64'd1);
        chk("done_busy", 64'(m.busy), 64'd0);
        chk("done_count", 64'(m.word_count), 64'd90);

        // valid_in while DONE is refused
        m.valid_in = 1'b1; m.data_in = 32'hBAD0_0003;
        chk("done_ready", 64'(m.ready), 64'd0);
        step(); step();
        m.valid_in = 1'b0;
        chk("done_hold_count", 64'(m.word_count), 64'd90);
        chk("done_hold", 64'(m.done), 64'd1);

        // start in DONE opens a new frame from address 0
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        chk("restart_done", 64'(m.done), 64'd0);
        chk("restart_busy", 64'(m.busy), 64'd1);
        chk("restart_count", 64'(m.word_count), 64'd0);

        // Toggling valid_in: writes only on valid cycles, contiguous addresses
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send0(32'hE000_0000 | 32'(i / 2), i / 2);
            else step();
        end
        chk("toggle_count", 64'(m.word_count), 64'd4);
        for (int i = 4; i < 40; i++) send0(32'hE000_0000 | 32'(i), i);
        chk("count40", 64'(m.word_count), 64'd40);

        // Reset mid-frame with a simultaneous offered word
        rst = 1'b1; m.valid_in = 1'b1; m.data_in = 32'hBAD0_0004;
        step();
        rst = 1'b0; m.valid_in = 1'b0;
        chk("midrst_count", 64'(m.word_count), 64'd0);
        chk("midrst_busy", 64'(m.busy), 64'd0);
        chk("midrst_ready", 64'(m.ready), 64'd0);
        chk("midrst_addr", 64'(m.sram_addr), 64'd0);
        chk("midrst_data", 64'(m.sram_data), 64'd0);
        step();
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        for (int i = 0; i < 3; i++) send0(32'hF000_0000 | 32'(i), i);
        chk("newframe_count", 64'(m.word_count), 64'd3);
        step(); step();

        // One-word frame
        s.start = 1'b1;
        step();
        s.start = 1'b0;
        chk("u1_busy", 64'(s.busy), 64'd1);
        s.valid_in = 1'b1; s.data_in = 32'h1234_5678;
        chk("u1_ready", 64'(s.ready), 64'd1);
        q1.push_back('{0, 32'h1234_5678, cyc + 1});
        step();
        s.valid_in = 1'b0;
        chk("u1_flush_busy", 64'(s.busy), 64'd1);
        chk("u1_flush_done", 64'(s.done), 64'd0);
        chk("u1_flush_count", 64'(s.word_count), 64'd1);
        chk("u1_flush_ready", 64'(s.ready), 64'd0);
        step();
        chk("u1_done", 64'(s.done), 64'd1);
        chk("u1_done_busy", 64'(s.busy), 64'd0);
        step(); step();

        chk("u0_queue_empty", 64'(q0.size()), 64'd0);
        chk("u1_queue_empty", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 Parameter MAX_ADDR, default 10, SHALL set the SRAM address width in bits.
REQ-002 Parameter DATA_SIZE, default 32, SHALL set the data word width in bits.
REQ-003 Parameter MAX_LOCATIONS, default 1024, SHALL set the SRAM depth in words.
REQ-004 Parameter MAX_INPUT, default 90, SHALL set the words per frame; legal range is 1..MAX_LOCATIONS.
REQ-005 Port pulse, input, 1 bit, SHALL be the only clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-007 Port start, input, 1 bit, SHALL be a one-cycle request to begin a frame.
REQ-008 Port valid_in, input, 1 bit, SHALL indicate that data_in holds a word offered by the producer.
REQ-009 Port data_in, input, DATA_SIZE bits, SHALL carry the offered word.
REQ-010 Port ready, output, 1 bit, SHALL indicate that the block accepts a word this cycle.
REQ-011 Port sram_we, output, 1 bit, SHALL be the SRAM write strobe.
REQ-012 Port sram_addr, output, MAX_ADDR bits, SHALL be the SRAM write address.
REQ-013 Port sram_data, output, DATA_SIZE bits, SHALL be the SRAM write data.
REQ-014 Port word_count, output, MAX_ADDR+1 bits, SHALL give the number of words accepted in the current frame.
REQ-015 Port busy, output, 1 bit, SHALL be high in states WRITE and FLUSH.
REQ-016 Port done, output, 1 bit, SHALL be high in state DONE.

Function
REQ-017 The FSM SHALL have four states: IDLE, WRITE, FLUSH and DONE.
REQ-018 IDLE->WRITE on start=1; the same edge SHALL clear the write pointer and word_count to 0.
REQ-019 DONE->WRITE on start=1; the same edge SHALL clear the write pointer and word_count to 0, and done SHALL drop.
REQ-020 start SHALL be ignored in WRITE and FLUSH.
REQ-021 ready SHALL be combinationally 1 only in WRITE, and only while word_count < MAX_INPUT.
REQ-022 A handshake (valid_in & ready) SHALL, at the next edge, set sram_we=1, sram_addr=write pointer and sram_data=data_in, and increment the pointer and word_count by 1.
REQ-023 sram_we, sram_addr and sram_data SHALL be registered outputs, giving one-cycle latency from handshake to write strobe.
REQ-024 sram_we SHALL be 0 in any cycle not preceded by a handshake; sram_addr and sram_data SHALL hold their last values when sram_we=0.
REQ-025 valid_in without ready SHALL cause no write, and no state or count change.
REQ-026 The handshake that brings word_count to MAX_INPUT SHALL move the FSM WRITE->FLUSH.
REQ-027 FLUSH SHALL last exactly one cycle, during which the last write strobe is presented, then move to DONE.
REQ-028 DONE SHALL hold word_count = MAX_INPUT until the next start.
REQ-029 Addresses SHALL be written strictly in order 0..MAX_INPUT-1, with no wrap-around within a frame.
REQ-030 The pointer SHALL never exceed MAX_LOCATIONS-1.
REQ-031 Back-to-back handshakes SHALL sustain one write per cycle.
REQ-032 If start and valid_in both arrive in IDLE, the word SHALL NOT be accepted, because ready=0 in IDLE.

Reset
REQ-033 rst=1 at an edge SHALL force state IDLE, pointer=0, word_count=0, sram_we=0, sram_addr=0, sram_data=0.
REQ-034 After reset, busy=0, done=0 and ready=0.
REQ-035 rst SHALL take priority over start and any handshake in the same cycle.
REQ-036 Reset mid-frame SHALL discard the frame; no sram_we pulse SHALL follow the reset edge.

Verification
REQ-037 Reset, then start, then 90 consecutive valid words D0..D89 -> sram_we high for 90 consecutive cycles at addr 0..89, one cycle after each handshake; FLUSH then done=1; word_count=90.
REQ-038 valid_in toggling 1,0,1,0 -> writes only on valid cycles; addresses contiguous; no write while valid_in=0.
REQ-039 valid_in=1 while IDLE or DONE -> ready=0, sram_we stays 0, word_count unchanged.
REQ-040 rst=1 after 40 accepted words -> next cycle IDLE, word_count=0, sram_we=0; a new start writes from addr 0 again.
REQ-041 MAX_INPUT=1: start, one word -> single write at addr 0, FLUSH for 1 cycle, then done=1.
REQ-042 start during WRITE at word 10 -> ignored; the frame completes normally at word_count=90; start in DONE -> new frame from addr 0 and done drops.
